fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the unified 8-bit, 256-deep memory.
- Owns the program counter and drives it as the memory's combinational fetch address. Captures the returned 8-bit instruction into a small prefetch FIFO.
- Presents instructions to decode over a valid/ready handshake. Handles branch redirects and halt.

Parameters:
- ADDR_WIDTH, 8, width of the PC and fetch address.
- INSTR_WIDTH, 8, instruction width returned by memory.
- FIFO_DEPTH, 2, prefetch entries; must be a power of 2 and at least 2.
- RESET_PC, 8'h00, PC value after reset.
- HALT_OPCODE, 8'hFF, instruction encoding that stops fetching.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- pc  output  ADDR_WIDTH  fetch address to memory; memory returns the instruction combinationally in the same cycle.
- instructions  input  INSTR_WIDTH  instruction byte from memory at pc.
- instr_out  output  INSTR_WIDTH  head-of-FIFO instruction to decode.
- instr_pc  output  ADDR_WIDTH  address of instr_out.
- instr_valid  output  1  FIFO non-empty.
- instr_ready  input  1  decode accepts the head entry this cycle.
- branch_taken  input  1  redirect request, single-cycle pulse.
- branch_target  input  ADDR_WIDTH  redirect address.
- halted  output  1  high while in the HALTED state.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, named rst.
- Reset values: pc=RESET_PC; FIFO count=0; FIFO storage=0; instr_out=0; instr_pc=0; instr_valid=0; halted=0; state=BOOT.
- rst has priority over every other input. Asserting rst mid-operation discards FIFO contents on the same edge.
- States:
  - BOOT: lasts exactly one cycle after reset deasserts; no fetch; then moves to RUN.
  - RUN: normal fetching.
  - HALTED: no fetch; pc frozen; halted=1.
- pop = instr_valid & instr_ready.
- push (RUN only) = ~branch_taken & (count<FIFO_DEPTH | pop).
- On push: the entry {pc, instructions} is written at the FIFO tail, and pc <= pc+1.
  - pc wraps modulo 2^ADDR_WIDTH, so 8'hFF goes to 8'h00.
- Fetch-to-valid latency is 1 cycle: an entry pushed at edge N is visible with instr_valid=1 after edge N.
- Full FIFO with simultaneous pop: push and pop happen together and count is unchanged.
- Empty FIFO: instr_ready is ignored.
- instr_out and instr_pc hold the head entry. They are stable while instr_valid=1 and instr_ready=0.
- Halt: if a pushed instruction equals HALT_OPCODE, it is still enqueued and delivered. pc is NOT incremented, and the state goes RUN->HALTED.
- Redirect (branch_taken=1, in RUN or HALTED):
  - FIFO flushed (count<=0), pc<=branch_target, no push that cycle, state<=RUN.
  - A pop in the same cycle counts as consumed; its entry is dropped by the flush.
  - branch_taken during BOOT is ignored.
- Decode order equals fetch order. No entry is duplicated or dropped except by a flush.

Optional Feature:
- Macro: FETCH_TRACE_EN.
- When defined, each push issues a simulation print, e.g. "--Fetch-- at address: <pc binary> : instr: <instr binary>".
- Each redirect prints "--Redirect-- to: <target binary>", and entry to HALTED prints "--Halted--".
- When undefined, no display statements are compiled. Functional behaviour is identical either way.

Decomposition:
- Package fetch_pkg holds:
  - the state typedef (BOOT, RUN, HALTED);
  - constants ADDR_W=8, INSTR_W=8, HALT_OP=8'hFF;
  - the packed FIFO entry type {pc, instr}.
- One sub-module, fetch_fifo: synchronous FIFO with push, pop, flush, count, and head output, parameterised by depth and entry width.
- fetch_unit keeps the PC register, the state machine, and the push/redirect logic.

Test Plan:
- Streaming: memory holds 8'h10..8'h1F at 0..15, rst for 2 cycles, instr_ready=1 constantly -> pc=0 during BOOT; the first instr_valid cycle shows instr_pc=0, instr_out=8'h10; then one new instruction per cycle in order.
- Backpressure: instr_ready=0 from cycle 3 -> exactly 2 entries buffered, pc stops at 2, instr_out held at 8'h10. Releasing instr_ready delivers 8'h10, 8'h11, 8'h12 with no gaps or duplicates.
- Redirect: with FIFO full holding pc 4,5, pulse branch_taken with target 8'h40 -> next cycle instr_valid=0 and pc=8'h40; following cycle instr_pc=8'h40.
- Wrap: redirect to 8'hFE -> instr_pc sequence 8'hFE, 8'hFF, 8'h00.
- Halt: 8'hFF at address 5 -> instr_out=8'hFF delivered with instr_pc=5, halted=1, pc frozen at 5, no further valids. A branch_taken to 8'h00 resumes fetching and clears halted.
- Reset mid-run: assert rst with 2 entries queued -> on the next edge instr_valid=0, pc=RESET_PC, halted=0, state BOOT.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Optional FETCH_TRACE_EN enables fetch/redirect/halt prints in fetch_unit.
package fetch_pkg;

    localparam int ADDR_W  = 8;
    localparam int INSTR_W = 8;
    localparam logic [INSTR_W-1:0] HALT_OP = 8'hFF;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HALTED
    } fetch_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO: synchronous push/pop, flush, head and full/empty flags.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = ADDR_W + INSTR_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_head,
    output logic             o_empty,
    output logic             o_full
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_rd;
    logic [PW-1:0]    r_wr;
    logic [CW-1:0]    r_count;
    logic             w_pop;
    logic             w_push;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == FULL_CNT);
    assign o_head  = r_mem[r_rd];
    assign w_pop   = i_pop & ~o_empty;
    assign w_push  = i_push & (~o_full | w_pop);

    // storage, pointers and occupancy; flush empties without touching storage
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr] <= i_data;
                r_wr        <= r_wr + PW'(1);
            end
            if (w_pop) r_rd <= r_rd + PW'(1);
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC, BOOT/RUN/HALTED control, prefetch FIFO to decode.
// Define FETCH_TRACE_EN to print fetch, redirect and halt events.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                     ADDR_WIDTH  = ADDR_W,
    parameter int                     INSTR_WIDTH = INSTR_W,
    parameter int                     FIFO_DEPTH  = 2,
    parameter logic [ADDR_WIDTH-1:0]  RESET_PC    = '0,
    parameter logic [INSTR_WIDTH-1:0] HALT_OPCODE = HALT_OP
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic [ADDR_WIDTH-1:0]  pc,
    input  logic [INSTR_WIDTH-1:0] instructions,
    output logic [INSTR_WIDTH-1:0] instr_out,
    output logic [ADDR_WIDTH-1:0]  instr_pc,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    input  logic                   branch_taken,
    input  logic [ADDR_WIDTH-1:0]  branch_target,
    output logic                   halted
);

    localparam int EW = ADDR_WIDTH + INSTR_WIDTH;

    fetch_state_t          r_state;
    fetch_state_t          w_next;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [ADDR_WIDTH-1:0] w_pc_next;
    logic [EW-1:0]         w_head;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_flush;
    logic                  w_is_halt;

    assign w_pop     = instr_valid & instr_ready;
    assign w_flush   = branch_taken & (r_state != BOOT);
    assign w_push    = (r_state == RUN) & ~branch_taken & (~w_full | w_pop);
    assign w_is_halt = (instructions == HALT_OPCODE);

    assign pc          = r_pc;
    assign instr_valid = ~w_empty;
    assign instr_pc    = w_head[EW-1:INSTR_WIDTH];
    assign instr_out   = w_head[INSTR_WIDTH-1:0];
    assign halted      = (r_state == HALTED);

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .i_data  ({r_pc, instructions}),
        .o_head  (w_head),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    // state and PC registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= BOOT;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_next;
            r_pc    <= w_pc_next;
        end
    end

    // next state and next PC; a fetched halt keeps the PC on itself
    always_comb begin
        w_next    = r_state;
        w_pc_next = r_pc;
        unique case (r_state)
            BOOT:   w_next = RUN;
            RUN:    if (w_push && w_is_halt) w_next = HALTED;
            HALTED: if (w_flush) w_next = RUN;
            default: w_next = BOOT;
        endcase
        if (w_flush)
            w_pc_next = branch_target;
        else if (w_push && !w_is_halt)
            w_pc_next = r_pc + ADDR_WIDTH'(1);
    end

`ifdef FETCH_TRACE_EN
    // simulation trace of fetch activity
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_push)
                $display("--Fetch-- at address: %b : instr: %b", r_pc, instructions);
            if (w_flush)
                $display("--Redirect-- to: %b", branch_target);
            if (r_state == RUN && w_next == HALTED)
                $display("--Halted--");
        end
    end
`else
    // trace compiled out
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed table-driven bench for fetch_unit with a behavioural memory.
// Each step drives inputs, takes one clock edge, then checks outputs.
module tb_fetch_unit;

    typedef struct {
        logic       rst;
        logic       rdy;
        logic       br;
        logic [7:0] tgt;
        logic       v;
        logic [7:0] out;
        logic [7:0] ipc;
        logic [7:0] pc;
        logic       h;
        logic       cd;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] pc;
    logic [7:0] instructions;
    logic [7:0] instr_out;
    logic [7:0] instr_pc;
    logic       instr_valid;
    logic       instr_ready;
    logic       branch_taken;
    logic [7:0] branch_target;
    logic       halted;

    logic [7:0] mem [256];
    int checks = 0;
    int errors = 0;
    vec_t tbl [$];

    assign instructions = mem[pc];

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk           (clk),
        .rst           (rst),
        .pc            (pc),
        .instructions  (instructions),
        .instr_out     (instr_out),
        .instr_pc      (instr_pc),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .halted        (halted)
    );

    function automatic vec_t mk(logic r, logic rd, logic b, logic [7:0] t,
                                logic v, logic [7:0] o, logic [7:0] ip,
                                logic [7:0] p, logic h, logic cd);
        vec_t x;
        x.rst = r; x.rdy = rd; x.br = b; x.tgt = t;
        x.v = v; x.out = o; x.ipc = ip; x.pc = p; x.h = h; x.cd = cd;
        return x;
    endfunction

    task automatic cmp(string name, int step, logic [7:0] act, logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, step, act, exp);
        end
    endtask

    task automatic run(vec_t x, int step);
        rst           = x.rst;
        instr_ready   = x.rdy;
        branch_taken  = x.br;
        branch_target = x.tgt;
        @(posedge clk);
        #1;
        cmp("instr_valid", step, {7'd0, instr_valid}, {7'd0, x.v});
        cmp("pc", step, pc, x.pc);
        cmp("halted", step, {7'd0, halted}, {7'd0, x.h});
        if (x.v || x.cd) begin
            cmp("instr_out", step, instr_out, x.out);
            cmp("instr_pc", step, instr_pc, x.ipc);
        end
    endtask

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = 8'(a) ^ 8'h80;
        for (int a = 0; a < 16; a++) mem[a] = 8'h10 + 8'(a);
        rst = 1'b1; instr_ready = 1'b1;
        branch_taken = 1'b0; branch_target = 8'h00;

        // streaming from reset
        tbl.push_back(mk(1, 1, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0, 1));
        tbl.push_back(mk(1, 1, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0, 1));
        tbl.push_back(mk(0, 1, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0, 0));
        tbl.push_back(mk(0, 1, 0, 8'h00, 1, 8'h10, 8'h00, 8'h01, 0, 0));
        tbl.push_back(mk(0, 1, 0, 8'h00, 1, 8'h11, 8'h01, 8'h02, 0, 0));
        tbl.push_back(mk(0, 1, 0, 8'h00, 1, 8'h12, 8'h02, 8'h03, 0, 0));
        // backpressure from boot
        tbl.push_back(mk(1, 0, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0, 1));
        tbl.push_back(mk(0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0, 0));
        tbl.push_back(mk(0, 0, 0, 8'h00, 1, 8'h10, 8'h00, 8'h01, 0, 0));
        tbl.push_back(mk(0, 0, 0, 8'h00, 1, 8'h10, 8'h00, 8'h02, 0, 0));
        tbl.push_back(mk(0, 0, 0, 8'h00, 1, 8'h10, 8'h00, 8'h02, 0, 0));
        tbl.push_back(mk(0, 0, 0, 8'h00, 1, 8'h10, 8'h00, 8'h02, 0, 0));
        tbl.push_back(mk(0, 1, 0, 8'h00, 1, 8'h11, 8'h01, 8'h03, 0, 0));
        tbl.push_back(mk(0, 1, 0, 8'h00, 1, 8'h12, 8'h02, 8'h04, 0, 0));
        tbl.push_back(mk(0, 1, 0, 8'h00, 1, 8'h13, 8'h03, 8'h05, 0, 0));
        tbl.push_back(mk(0, 1, 0, 8'h00, 1, 8'h14, 8'h04, 8'h06, 0, 0));
        tbl.push_back(mk(0, 0, 0, 8'h00, 1, 8'h14, 8'h04, 8'h06, 0, 0));
        // redirect with full FIFO {4,5}
        tbl.push_back(mk(0, 0, 1, 8'h40, 0, 8'h00, 8'h00, 8'h40, 0, 0));
        tbl.push_back(mk(0, 0, 0, 8'h00, 1, 8'hC0, 8'h40, 8'h41, 0, 0));
        // redirect with same-cycle pop, then wrap FE, FF, 00
        tbl.push_back(mk(0, 1, 1, 8'hFE, 0, 8'h00, 8'h00, 8'hFE, 0, 0));
        tbl.push_back(mk(0, 1, 0, 8'h00, 1, 8'h7E, 8'hFE, 8'hFF, 0, 0));
        tbl.push_back(mk(0, 1, 0, 8'h00, 1, 8'h7F, 8'hFF, 8'h00, 0, 0));
        tbl.push_back(mk(0, 1, 0, 8'h00, 1, 8'h10, 8'h00, 8'h01, 0, 0));

        for (int i = 0; i < tbl.size(); i++) run(tbl[i], i);

        // halt at address 5, then resume by redirect
        mem[5] = 8'hFF;
        run(mk(0, 1, 1, 8'h03, 0, 8'h00, 8'h00, 8'h03, 0, 0), 100);
        run(mk(0, 1, 0, 8'h00, 1, 8'h13, 8'h03, 8'h04, 0, 0), 101);
        run(mk(0, 1, 0, 8'h00, 1, 8'h14, 8'h04, 8'h05, 0, 0), 102);
        run(mk(0, 1, 0, 8'h00, 1, 8'hFF, 8'h05, 8'h05, 1, 0), 103);
        run(mk(0, 1, 0, 8'h00, 0, 8'h00, 8'h00, 8'h05, 1, 0), 104);
        run(mk(0, 1, 0, 8'h00, 0, 8'h00, 8'h00, 8'h05, 1, 0), 105);
        run(mk(0, 1, 1, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0, 0), 106);
        run(mk(0, 1, 0, 8'h00, 1, 8'h10, 8'h00, 8'h01, 0, 0), 107);
        mem[5] = 8'h15;

        // reset with two entries queued; branch during boot is ignored
        run(mk(0, 0, 0, 8'h00, 1, 8'h10, 8'h00, 8'h02, 0, 0), 200);
        run(mk(1, 0, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0, 1), 201);
        run(mk(0, 1, 1, 8'h40, 0, 8'h00, 8'h00, 8'h00, 0, 0), 202);
        run(mk(0, 1, 0, 8'h00, 1, 8'h10, 8'h00, 8'h01, 0, 0), 203);
        run(mk(0, 1, 0, 8'h00, 1, 8'h11, 8'h01, 8'h02, 0, 0), 204);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
